// File: rtl/control_mayor_2b.sv
// Sequential max-finder: accepts N_ELEM 2-bit values, reports the maximum and its first index.
// Optional macro CTRL_MAYOR_EARLY_EXIT_EN ends the burst as soon as the ceiling value 3 is seen.
module control_mayor_2b #(
  parameter int N_ELEM = 4,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [1:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       max_val,
  output logic [IDX_W-1:0] max_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] count;
  logic             xfer;
  logic             early_hit;
  logic             last_elem;

  assign xfer      = in_valid & in_ready;
  assign last_elem = (count == LAST);

  // Seeing the ceiling value means no later element can beat it.
`ifdef CTRL_MAYOR_EARLY_EXIT_EN
  assign early_hit = (in_data == 2'd3);
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else begin
      state <= state_next;
      if (xfer && state == LOAD) begin
        max_val <= in_data;
        max_idx <= '0;
        count   <= IDX_W'(1);
      end else if (xfer && state == SCAN) begin
        // Strict compare so ties keep the earlier index.
        if (in_data > max_val) begin
          max_val <= in_data;
          max_idx <= count;
        end
        if (!last_elem) begin
          count <= count + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (N_ELEM == 1 || early_hit) begin
            state_next = DONE;
          end else begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && (last_elem || early_hit)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_mayor_2b.sv
// Randomized scoreboard bench for control_mayor_2b; expected results come from a
// max/first-index model of each burst and are checked when done pulses.
module tb_control_mayor_2b;

  localparam int N_ELEM = 4;
  localparam int IDX_W  = 2;

  typedef logic [1:0] burst_t [N_ELEM];
  typedef struct {
    int val;
    int idx;
  } result_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [1:0]       in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [1:0]       max_val;
  logic [IDX_W-1:0] max_idx;

  int      vectors;
  int      miscompares;
  int      done_seen;
  int      done_expected;
  result_t exp_q[$];

  control_mayor_2b #(.N_ELEM(N_ELEM), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .max_idx  (max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: largest value, lowest index holding it, and how many elements are taken.
  function automatic void model(input burst_t d, output int n_acc, output int mv, output int mi);
    mv    = -1;
    mi    = 0;
    n_acc = 0;
    for (int k = 0; k < N_ELEM; k++) begin
      n_acc = k + 1;
      if (int'(d[k]) > mv) begin
        mv = int'(d[k]);
        mi = k;
      end
`ifdef CTRL_MAYOR_EARLY_EXIT_EN
      if (d[k] == 2'd3) break;
`endif
    end
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding burst.
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_done", 1, 0);
      end else begin
        result_t r;
        r = exp_q.pop_front();
        checkOutput("max_val", int'(max_val), r.val);
        checkOutput("max_idx", int'(max_idx), r.idx);
      end
    end
  end

  task automatic checkIdleOutputs(input string tag, input int mv, input int mi);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_max_val"}, int'(max_val), mv);
    checkOutput({tag, "_max_idx"}, int'(max_idx), mi);
  endtask

  task automatic applyStimulus(input burst_t d, input int gap_lo, input int gap_hi, input bit poke);
    int n_acc, mv, mi, gap;
    result_t r;
    model(d, n_acc, mv, mi);
    r.val = mv;
    r.idx = mi;
    exp_q.push_back(r);
    done_expected++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n_acc; k++) begin
      gap = int'($urandom_range(gap_hi, gap_lo));
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 2'($urandom);
        start    = poke ? 1'($urandom) : 1'b0;
        @(negedge clk);
        checkOutput("stall_busy", int'(busy), 1);
      end
      in_valid = 1'b1;
      in_data  = d[k];
      start    = poke ? 1'($urandom) : 1'b0;
      checkOutput("in_ready", int'(in_ready), 1);
      @(negedge clk);
    end
    // Final transfer just happened: done must be up now, and start here is ignored.
    in_valid = 1'b1;
    in_data  = 2'($urandom);
    start    = poke;
    checkOutput("done_latency", int'(done), 1);
    @(negedge clk);
    start = 1'b0;
    checkIdleOutputs("idle1", mv, mi);
    @(negedge clk);
    checkIdleOutputs("idle2", mv, mi);
    in_valid = 1'b0;
  endtask

  initial begin
    burst_t b;
    vectors       = 0;
    miscompares   = 0;
    done_seen     = 0;
    done_expected = 0;
    rst      = 1'b1;
    start    = 1'($urandom);
    in_valid = 1'($urandom);
    in_data  = 2'($urandom);

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkIdleOutputs("reset", 0, 0);
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 2'($urandom);
    end
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;

    b = '{2'd1, 2'd2, 2'd0, 2'd2};
    applyStimulus(b, 0, 0, 1'b0);
    applyStimulus(b, 3, 3, 1'b0);
    b = '{2'd3, 2'd0, 2'd1, 2'd2};
    applyStimulus(b, 0, 0, 1'b0);

    // Abort mid-burst: no done may follow, outputs return to zero.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 2'd2;
    @(negedge clk);
`ifdef CTRL_MAYOR_EARLY_EXIT_EN
    in_data = 2'd1;
`else
    in_data = 2'd3;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdleOutputs("abort", 0, 0);
    repeat (3) @(negedge clk);
    checkIdleOutputs("abort_hold", 0, 0);

    b = '{2'd0, 2'd0, 2'd0, 2'd1};
    applyStimulus(b, 0, 1, 1'b0);
    b = '{2'd2, 2'd1, 2'd2, 2'd0};
    applyStimulus(b, 1, 2, 1'b1);

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < N_ELEM; k++) b[k] = 2'($urandom);
      applyStimulus(b, 0, 2, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    checkOutput("done_count", done_seen, done_expected);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
